uart_tx_fifo: RTL and testbench

- Transmit-side buffer that sits directly upstream of UART_rs232_tx.
- Accepts bytes from a producer through a single-cycle write strobe and stores them in a circular FIFO.
- Presents one byte at a time on TxData/TxEn to the transmitter.
- Pops the next byte only after the transmitter pulses TxDone, so the producer is decoupled from the serial baud rate.

---
 rtl/uart_tx_fifo.sv | 111 +++++++++++
 tb/tb_uart_tx_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO feeding UART_rs232_tx: buffers producer writes and
// hands one byte at a time to the transmitter, popping the next on TxDone.
module uart_tx_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              WrEn,
  input  logic [DATA_W-1:0] WrData,
  input  logic              Flush,
  output logic              Full,
  output logic              Empty,
  output logic [ADDR_W:0]   Count,
  output logic              Overflow,
  output logic              TxEn,
  output logic [DATA_W-1:0] TxData,
  input  logic              TxDone
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DepthCount = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, SEND} stateT;

  stateT             state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wPtr;
  logic [ADDR_W-1:0] rPtr;
  logic [ADDR_W:0]   countNext;
  logic              doWrite;
  logic              doPop;
  logic              dropWrite;

  // Full is the registered flag, so a write against a full FIFO is dropped
  // even when a pop frees a slot on the same edge; Flush outranks everything.
  always_comb begin
    doWrite   = WrEn && !Full && !Flush;
    doPop     = (state == IDLE) && !Empty && !Flush;
    dropWrite = WrEn && Full && !Flush;
    countNext = Count;
    if (Flush) begin
      countNext = '0;
    end else begin
      case ({doWrite, doPop})
        2'b10:   countNext = Count + (ADDR_W + 1)'(1);
        2'b01:   countNext = Count - (ADDR_W + 1)'(1);
        default: countNext = Count;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (doWrite) begin
      mem[wPtr] <= WrData;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wPtr     <= '0;
      rPtr     <= '0;
      Count    <= '0;
      Full     <= 1'b0;
      Empty    <= 1'b1;
      Overflow <= 1'b0;
    end else begin
      Count    <= countNext;
      Full     <= (countNext == DepthCount);
      Empty    <= (countNext == '0);
      Overflow <= dropWrite;
      if (Flush) begin
        wPtr <= '0;
        rPtr <= '0;
      end else begin
        if (doWrite) wPtr <= wPtr + ADDR_W'(1);
        if (doPop)   rPtr <= rPtr + ADDR_W'(1);
      end
    end
  end

  // A byte already handed to the transmitter survives Flush and completes.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= IDLE;
      TxEn   <= 1'b0;
      TxData <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (doPop) begin
            TxData <= mem[rPtr];
            TxEn   <= 1'b1;
            state  <= SEND;
          end
        end
        SEND: begin
          if (TxDone) begin
            TxEn  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          TxEn  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo with hand-computed expectations.
module tb_uart_tx_fifo;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       WrEn;
  logic [7:0] WrData;
  logic       Flush;
  logic       Full;
  logic       Empty;
  logic [4:0] Count;
  logic       Overflow;
  logic       TxEn;
  logic [7:0] TxData;
  logic       TxDone;

  int assertCount = 0;
  int failCount   = 0;

  uart_tx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .WrEn(WrEn), .WrData(WrData), .Flush(Flush),
    .Full(Full), .Empty(Empty), .Count(Count), .Overflow(Overflow),
    .TxEn(TxEn), .TxData(TxData), .TxDone(TxDone)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] data);
    WrEn   = 1'b1;
    WrData = data;
    tick();
    WrEn   = 1'b0;
  endtask

  task automatic pulseDone();
    TxDone = 1'b1;
    tick();
    TxDone = 1'b0;
  endtask

  logic [7:0] base;

  initial begin
    Rst_n = 1'b0; WrEn = 1'b0; WrData = '0; Flush = 1'b0; TxDone = 1'b0;
    repeat (3) tick();
    checkOutput("rstEmpty", 32'(Empty), 1);
    checkOutput("rstFull", 32'(Full), 0);
    checkOutput("rstCount", 32'(Count), 0);
    checkOutput("rstTxEn", 32'(TxEn), 0);
    checkOutput("rstTxData", 32'(TxData), 0);
    checkOutput("rstOverflow", 32'(Overflow), 0);
    Rst_n = 1'b1;
    tick();

    // Single byte latency
    applyStimulus(8'hA5);
    checkOutput("lat1Empty", 32'(Empty), 0);
    checkOutput("lat1Count", 32'(Count), 1);
    checkOutput("lat1TxEn", 32'(TxEn), 0);
    tick();
    checkOutput("lat2TxEn", 32'(TxEn), 1);
    checkOutput("lat2TxData", 32'(TxData), 8'hA5);
    checkOutput("lat2Count", 32'(Count), 0);
    repeat (3) tick();
    pulseDone();
    checkOutput("doneTxEn", 32'(TxEn), 0);
    checkOutput("doneEmpty", 32'(Empty), 1);
    tick();

    // Fill: first byte is popped, so 16 writes leave 15 queued
    for (int i = 0; i < 16; i++) applyStimulus(8'(i));
    checkOutput("fillCount15", 32'(Count), 15);
    checkOutput("fillFull15", 32'(Full), 0);
    checkOutput("fillTxData", 32'(TxData), 8'h00);
    applyStimulus(8'h10);
    checkOutput("fillCount16", 32'(Count), 16);
    checkOutput("fillFull16", 32'(Full), 1);
    checkOutput("fillOvf16", 32'(Overflow), 0);
    applyStimulus(8'h11);
    checkOutput("ovfPulse", 32'(Overflow), 1);
    checkOutput("ovfCount", 32'(Count), 16);
    tick();
    checkOutput("ovfClear", 32'(Overflow), 0);

    // Drain 0x00..0x10 with one idle cycle between bytes
    for (int i = 0; i <= 16; i++) begin
      checkOutput($sformatf("drainEn%0d", i), 32'(TxEn), 1);
      checkOutput($sformatf("drainData%0d", i), 32'(TxData), 32'(i));
      repeat (18) tick();
      checkOutput($sformatf("drainHold%0d", i), 32'(TxData), 32'(i));
      pulseDone();
      checkOutput($sformatf("drainGap%0d", i), 32'(TxEn), 0);
      tick();
      if (i < 16) checkOutput($sformatf("drainNext%0d", i), 32'(TxEn), 1);
    end
    checkOutput("drainIdle", 32'(TxEn), 0);
    checkOutput("drainEmpty", 32'(Empty), 1);
    checkOutput("drainCount", 32'(Count), 0);

    // Wrap-around: 8 batches of 5 bytes, values 0x40..0x67
    for (int b = 0; b < 8; b++) begin
      base = 8'(8'h40 + 5 * b);
      for (int j = 0; j < 5; j++) applyStimulus(8'(base + 8'(j)));
      checkOutput($sformatf("wrapCount%0d", b), 32'(Count), 4);
      for (int j = 0; j < 5; j++) begin
        checkOutput($sformatf("wrapData%0d_%0d", b, j), 32'(TxData), 32'(base + 8'(j)));
        checkOutput($sformatf("wrapOvf%0d_%0d", b, j), 32'(Overflow), 0);
        pulseDone();
        tick();
      end
    end
    checkOutput("wrapEmpty", 32'(Empty), 1);

    // Write coinciding with an IDLE pop while Count=3
    for (int j = 0; j < 4; j++) applyStimulus(8'(8'h31 + j));
    checkOutput("simPreCount", 32'(Count), 3);
    pulseDone();
    checkOutput("simIdleCount", 32'(Count), 3);
    applyStimulus(8'h35);
    checkOutput("simCount", 32'(Count), 3);
    checkOutput("simTxEn", 32'(TxEn), 1);
    for (int j = 1; j < 5; j++) begin
      checkOutput($sformatf("simData%0d", j), 32'(TxData), 32'(8'h31 + j));
      pulseDone();
      tick();
    end
    checkOutput("simEmpty", 32'(Empty), 1);

    // Flush during SEND with a concurrent write
    for (int j = 0; j < 6; j++) applyStimulus(8'(8'h60 + j));
    checkOutput("flPreCount", 32'(Count), 5);
    Flush = 1'b1; WrEn = 1'b1; WrData = 8'h77;
    tick();
    Flush = 1'b0; WrEn = 1'b0;
    checkOutput("flCount", 32'(Count), 0);
    checkOutput("flEmpty", 32'(Empty), 1);
    checkOutput("flFull", 32'(Full), 0);
    checkOutput("flOvf", 32'(Overflow), 0);
    checkOutput("flTxEn", 32'(TxEn), 1);
    checkOutput("flTxData", 32'(TxData), 8'h60);
    repeat (4) tick();
    checkOutput("flHold", 32'(TxData), 8'h60);
    pulseDone();
    checkOutput("flDone", 32'(TxEn), 0);
    repeat (3) tick();
    checkOutput("flStayIdle", 32'(TxEn), 0);
    checkOutput("flStayEmpty", 32'(Empty), 1);

    // Async reset in the middle of a SEND cycle
    applyStimulus(8'h88);
    applyStimulus(8'h89);
    checkOutput("arTxEn", 32'(TxEn), 1);
    checkOutput("arCount", 32'(Count), 1);
    #2;
    Rst_n = 1'b0;
    #1;
    checkOutput("arTxEnLow", 32'(TxEn), 0);
    checkOutput("arTxData", 32'(TxData), 0);
    checkOutput("arCountZero", 32'(Count), 0);
    checkOutput("arEmpty", 32'(Empty), 1);
    tick();
    Rst_n = 1'b1;
    repeat (2) tick();
    checkOutput("arStayIdle", 32'(TxEn), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
